// File: rtl/operand_mux_pipe.sv
// operand_mux_pipe: N-way ALU B-operand selector with a registered valid/ready output.
// Define OPERAND_MUX_SKID_EN to add a skid register that breaks the out_ready->in_ready path.
module operand_mux_pipe #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2,
  parameter int SEL_W = $clog2(N_IN),
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      data_out,
  output logic                  sel_err,
  input  logic                  clear_err,
  output logic [CNT_W-1:0]      xfer_count
);

  logic             accept;
  logic             release_x;
  logic             sel_oor;
  logic [WIDTH-1:0] sel_word;

  // Out-of-range select yields a zero word; in-range picks operand[sel].
  always_comb begin
    sel_word = '0;
    sel_oor  = ({1'b0, sel} >= (SEL_W+1)'(N_IN));
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign accept    = in_valid && in_ready;
  assign release_x = out_valid && out_ready;

`ifdef OPERAND_MUX_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  assign in_ready = !skid_valid;

  // Output register backed by one skid slot; a stalled accept parks in the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        data_out  <= sel_word;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= sel_word;
        skid_valid <= 1'b1;
      end
    end else if (release_x) begin
      if (skid_valid) begin
        data_out   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  // Single output register; a new word may replace the one being released.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else if (accept) begin
      data_out  <= sel_word;
      out_valid <= 1'b1;
    end else if (release_x) begin
      out_valid <= 1'b0;
    end
  end
`endif

  // Sticky select error; a same-cycle set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err <= 1'b1;
    end else if (clear_err) begin
      sel_err <= 1'b0;
    end
  end

  // Saturating count of output handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (release_x && (xfer_count != '1)) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_operand_mux_pipe.sv
// tb_operand_mux_pipe: directed checks for operand_mux_pipe.
// Covers N_IN=2, N_IN=3 and CNT_W=4 instances; follows OPERAND_MUX_SKID_EN.
module tb_operand_mux_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // u2: N_IN=2, WIDTH=8
  logic        v2, r2, ov2, or2, err2, clr2;
  logic [0:0]  s2;
  logic [15:0] d2;
  logic [7:0]  q2;
  logic [15:0] c2;

  // u3: N_IN=3
  logic        v3, r3, ov3, or3, err3, clr3;
  logic [1:0]  s3;
  logic [23:0] d3;
  logic [7:0]  q3;
  logic [15:0] c3;

  // u4: CNT_W=4
  logic        v4, r4, ov4, or4, err4, clr4;
  logic [0:0]  s4;
  logic [15:0] d4;
  logic [7:0]  q4;
  logic [3:0]  c4;

  operand_mux_pipe #(.WIDTH(8), .N_IN(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .sel(s2),
    .data_in(d2), .out_valid(ov2), .out_ready(or2), .data_out(q2),
    .sel_err(err2), .clear_err(clr2), .xfer_count(c2)
  );

  operand_mux_pipe #(.WIDTH(8), .N_IN(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .sel(s3),
    .data_in(d3), .out_valid(ov3), .out_ready(or3), .data_out(q3),
    .sel_err(err3), .clear_err(clr3), .xfer_count(c3)
  );

  operand_mux_pipe #(.WIDTH(8), .N_IN(2), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .sel(s4),
    .data_in(d4), .out_valid(ov4), .out_ready(or4), .data_out(q4),
    .sel_err(err4), .clear_err(clr4), .xfer_count(c4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp;

  initial begin
    v2 = 0; or2 = 1; clr2 = 0; s2 = 0; d2 = '0;
    v3 = 0; or3 = 1; clr3 = 0; s3 = 0; d3 = '0;
    v4 = 0; or4 = 1; clr4 = 0; s4 = 0; d4 = '0;

    // reset state
    step(); step();
    rst = 0;
    check("rst_ov", ov2, 0);
    check("rst_q", q2, 0);
    check("rst_cnt", c2, 0);
    check("rst_err", err2, 0);
    check("rst_rdy", r2, 1);

    // basic select
    d2 = 16'hB25A; s2 = 0; v2 = 1; or2 = 1;
    step();
    check("sel0_ov", ov2, 1);
    check("sel0_q", q2, 8'h5A);
    s2 = 1;
    step();
    check("sel1_q", q2, 8'hB2);
    check("sel1_cnt", c2, 1);
    v2 = 0;
    step();
    check("drain_ov", ov2, 0);
    check("drain_q", q2, 8'hB2);
    check("drain_cnt", c2, 2);

    // stall
    d2 = 16'hB25A; s2 = 0; v2 = 1; or2 = 0;
    step();
    check("stall_q0", q2, 8'h5A);
`ifdef OPERAND_MUX_SKID_EN
    check("stall_rdy0", r2, 1);
`else
    check("stall_rdy0", r2, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      d2 = {8'hC0 + 8'(i), 8'hD0 + 8'(i)}; s2 = 1;
      step();
      check("stall_q", q2, 8'h5A);
      check("stall_ov", ov2, 1);
      check("stall_rdy", r2, 0);
    end
    v2 = 0; or2 = 1;
    step();
    check("unstall_cnt", c2, 3);
`ifdef OPERAND_MUX_SKID_EN
    check("skid_ov", ov2, 1);
    check("skid_q", q2, 8'hC0);
    step();
    check("skid_ov2", ov2, 0);
    check("skid_cnt", c2, 4);
`else
    check("unstall_ov", ov2, 0);
    check("unstall_q", q2, 8'h5A);
`endif

    // out-of-range select on N_IN=3
    d3 = 24'h112233; s3 = 3; v3 = 1; or3 = 1;
    step();
    check("oor_ov", ov3, 1);
    check("oor_q", q3, 8'h00);
    check("oor_err", err3, 1);
    s3 = 2;
    step();
    check("sel2_q", q3, 8'h11);
    check("sel2_err", err3, 1);
    s3 = 1;
    step();
    check("sel1n3_q", q3, 8'h22);
    v3 = 0; clr3 = 1;
    step();
    check("clr_err", err3, 0);
    v3 = 1; s3 = 3; clr3 = 1;
    step();
    check("setwins_err", err3, 1);
    check("setwins_q", q3, 8'h00);
    v3 = 0; clr3 = 0;
    step();

    // saturation on CNT_W=4
    d4 = 16'h1234; s4 = 0; v4 = 1; or4 = 1;
    repeat (16) step();
    check("sat15_cnt", c4, 4'hF);
    repeat (5) step();
    check("sat20_cnt", c4, 4'hF);
    v4 = 0;
    step();
    check("sat_hold", c4, 4'hF);

    // reset mid-operation
    d2 = 16'hB25A; s2 = 0; v2 = 1; or2 = 0;
    step();
    d2 = 16'h7766;
    step();
    check("pre_rst_ov", ov2, 1);
    v2 = 0;
    rst = 1;
    step();
    rst = 0;
    check("mrst_ov", ov2, 0);
    check("mrst_q", q2, 0);
    check("mrst_cnt", c2, 0);
    check("mrst_rdy", r2, 1);
    check("mrst_err3", err3, 0);
    or2 = 1;
    step();
    check("mrst_empty", ov2, 0);

    // back-to-back streaming
    or2 = 1; v2 = 1;
    for (int i = 0; i < 1000; i++) begin
      s2 = 1'($urandom_range(0, 1));
      d2 = 16'($urandom);
      exp = d2[s2*8 +: 8];
      step();
      check("str_ov", ov2, 1);
      check("str_q", q2, exp);
    end
    v2 = 0;
    step();
    check("str_cnt", c2, 1000);
    check("str_end_ov", ov2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
